hea_key_expand: RTL and testbench
=================================

# hea_key_expand

Iterative AES-128 key-schedule engine feeding the round datapath. It accepts one 128-bit cipher key over a valid/ready handshake and emits the 11 round keys (index 0..10), one per accepted output beat, over a second valid/ready handshake. It reuses the shared GF(2^8) helpers and word rotation from `hea_func_pack`. One S-box sub-module supplies SubWord.

## Interface
- `NR`, 10: number of rounds. Round keys emitted are indices 0..NR. Only 10 is supported.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_valid`  in  1: `key_in` is valid.
- `key_ready`  out  1: engine idle and able to take a key.
- `key_in`  in  128: cipher key. `[127:96]` is w0, `[31:0]` is w3.
- `rk_valid`  out  1: `rk_data` holds round key `rk_idx`.
- `rk_ready`  in  1: consumer accepts the current round key.
- `rk_data`  out  128: round key, using the same word ordering as `key_in`.
- `rk_idx`  out  4: round index of `rk_data`, 0..10.
- `rk_last`  out  1: `rk_valid && rk_idx == NR`.
- `busy`  out  1: high in EMIT.

## Operation
- **FSM states:**
  - IDLE: `key_ready = 1`, `rk_valid = 0`.
  - EMIT: `key_ready = 0`, `rk_valid = 1`.
- **IDLE → EMIT** on `key_valid && key_ready`. On that edge:
  - `rk_data <= key_in`
  - `rk_idx <= 0`
  - `rcon <= 8'h01`
- **EMIT, `rk_ready = 0`:** all registers hold. `rk_data` and `rk_idx` stay stable.
- **EMIT, `rk_ready = 1`, `rk_idx < NR`:**
  - `rk_data <= next_key(rk_data, rcon)`
  - `rk_idx <= rk_idx + 1`
  - `rcon <= gfmul2(rcon)`
- **EMIT, `rk_ready = 1`, `rk_idx == NR`:** go to IDLE. `rk_data` and `rk_idx` keep their last values.
- **`next_key` (w0..w3 from the current key):**
  - t = sub_word(rot_word(w3)) ^ {rcon, 24'h0}, with rot_word(w) = {w[23:0], w[31:24]}.
  - n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2.
  - sub_word applies the AES S-box to each of the 4 bytes.
- **rcon sequence** for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. gfmul2 reduces modulo 0x11B, so 80 → 1b.
- `key_valid` while in EMIT is ignored; no key is captured.
- **Reset (asserted at any time, including mid-EMIT):**
  - State goes to IDLE; the partial schedule is discarded.
  - `rk_data = 0`, `rk_idx = 0`, `rcon = 8'h01`, `rk_valid = 0`, `rk_last = 0`, `busy = 0`.
  - `key_ready = 1` once reset is released.

## Timing
- **Key to first round key:** key accepted at edge N → rk0 valid after edge N (in cycle N+1).
- **Throughput:** with `rk_ready` held high, one round key per cycle. Cycles N+1 .. N+11 carry rk0 .. rk10.
- **Return to idle:** the final handshake (rk10) at edge M → `key_ready = 1` in cycle M+1. The earliest next key capture is edge M+1.
- **Combinational logic:** the whole `next_key` datapath is one register-to-register path, through 4 S-boxes and the XOR chain. There is no combinational path from inputs to outputs.
- **Output decode:**
  - `key_ready`, `rk_valid` and `busy` decode from the state register only.
  - `rk_last` decodes from the state register and `rk_idx`.

## Structure
- **`hea_func_pack` additions:**
  - `rot_word` and `gfmul2` (already shared) are used as-is.
  - Add `localparam logic [7:0] AES_RCON [1:10]` for verification cross-checks.
  - Add the `typedef enum logic {IDLE, EMIT}` state type.
- **Sub-module `hea_sbox`:**
  - Purely combinational, 8-bit in and 8-bit out, forward AES S-box.
  - Instantiated 4× for sub_word.
  - Reused later by the SubBytes stage.
- **Top level:** FSM, index counter, rcon register, 128-bit key register.

## Test plan
- **FIPS-197 vector:** key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready = 1` → rk1 = a0fafe1788542cb123a339392a6c7605, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last = 1`. Exactly 11 beats in consecutive cycles.
- **All-zero key:** → rk1 = 62636363626363636263636362636363, rk2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
- **Backpressure:** random `rk_ready` (50%) on the FIPS key → identical 11-key sequence. `rk_data` and `rk_idx` stay stable during every stall cycle.
- **Key while busy:** `key_valid` pulsed with a different key during EMIT → ignored. The schedule completes for the original key.
- **Reset mid-schedule:** `rst_n` low at rk_idx = 5 → outputs go to reset values immediately. A new key after release yields a correct rk0..rk10.
- **Back-to-back keys:** second key presented with `key_valid` held high → captured at the edge after rk10's handshake. Its rk0 appears exactly 2 cycles after rk10 was accepted.

Source files
------------

// File: rtl/hea_func_pack.sv
// Shared GF(2^8) and word helpers for the HEA datapath, plus the key-schedule
// state type and the AES round-constant table.
package hea_func_pack;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } hea_ke_state_e;

  localparam logic [7:0] AES_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gfmul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = gfmul2(x);
    end
    return p;
  endfunction

  // Affine map of the forward S-box: b ^ rotl1..4(b) ^ 0x63.
  function automatic logic [7:0] aes_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/hea_sbox.sv
// Forward AES S-box, purely combinational: GF(2^8) inverse as x^254 followed
// by the affine map. Shared by the key schedule and the SubBytes stage.
module hea_sbox
  import hea_func_pack::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] x2_s;
  logic [7:0] x3_s;
  logic [7:0] x6_s;
  logic [7:0] x12_s;
  logic [7:0] x15_s;
  logic [7:0] x30_s;
  logic [7:0] x60_s;
  logic [7:0] x120_s;
  logic [7:0] x240_s;
  logic [7:0] x252_s;
  logic [7:0] inv_s;

  // Addition chain 254 = 240 + 12 + 2; zero maps to zero without a special case.
  always_comb begin
    x2_s     = gfmul(in_byte, in_byte);
    x3_s     = gfmul(x2_s, in_byte);
    x6_s     = gfmul(x3_s, x3_s);
    x12_s    = gfmul(x6_s, x6_s);
    x15_s    = gfmul(x12_s, x3_s);
    x30_s    = gfmul(x15_s, x15_s);
    x60_s    = gfmul(x30_s, x30_s);
    x120_s   = gfmul(x60_s, x60_s);
    x240_s   = gfmul(x120_s, x120_s);
    x252_s   = gfmul(x240_s, x12_s);
    inv_s    = gfmul(x252_s, x2_s);
    out_byte = aes_affine(inv_s);
  end

endmodule

// File: rtl/hea_key_expand.sv
// Iterative AES-128 key schedule: takes one cipher key and streams round keys
// 0..NR, one per accepted output beat, over a valid/ready handshake.
module hea_key_expand
  import hea_func_pack::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  hea_ke_state_e state_q;
  hea_ke_state_e state_d;
  logic [127:0]  rk_data_q;
  logic [127:0]  rk_data_d;
  logic [3:0]    rk_idx_q;
  logic [3:0]    rk_idx_d;
  logic [7:0]    rcon_q;
  logic [7:0]    rcon_d;

  logic [31:0]   w0_s;
  logic [31:0]   w1_s;
  logic [31:0]   w2_s;
  logic [31:0]   w3_s;
  logic [31:0]   rot_s;
  logic [31:0]   sub_s;
  logic [31:0]   t_s;
  logic [31:0]   n0_s;
  logic [31:0]   n1_s;
  logic [31:0]   n2_s;
  logic [31:0]   n3_s;
  logic [127:0]  next_key_s;

  assign w0_s  = rk_data_q[127:96];
  assign w1_s  = rk_data_q[95:64];
  assign w2_s  = rk_data_q[63:32];
  assign w3_s  = rk_data_q[31:0];
  assign rot_s = rot_word(w3_s);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    hea_sbox u_sbox (
      .in_byte  (rot_s[8*g +: 8]),
      .out_byte (sub_s[8*g +: 8])
    );
  end

  assign t_s        = sub_s ^ {rcon_q, 24'h000000};
  assign n0_s       = w0_s ^ t_s;
  assign n1_s       = w1_s ^ n0_s;
  assign n2_s       = w2_s ^ n1_s;
  assign n3_s       = w3_s ^ n2_s;
  assign next_key_s = {n0_s, n1_s, n2_s, n3_s};

  // Keys arriving during EMIT are ignored; the last key stays on rk_data after EMIT.
  always_comb begin
    state_d   = state_q;
    rk_data_d = rk_data_q;
    rk_idx_d  = rk_idx_q;
    rcon_d    = rcon_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d   = EMIT;
          rk_data_d = key_in;
          rk_idx_d  = 4'd0;
          rcon_d    = 8'h01;
        end else begin
          state_d   = IDLE;
        end
      end
      EMIT: begin
        if (!rk_ready) begin
          state_d = EMIT;
        end else if (rk_idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          rk_data_d = next_key_s;
          rk_idx_d  = rk_idx_q + 4'd1;
          rcon_d    = gfmul2(rcon_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rk_data_q <= 128'h0;
      rk_idx_q  <= 4'd0;
      rcon_q    <= 8'h01;
    end else begin
      state_q   <= state_d;
      rk_data_q <= rk_data_d;
      rk_idx_q  <= rk_idx_d;
      rcon_q    <= rcon_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign rk_last   = (state_q == EMIT) && (rk_idx_q == LAST_IDX);
  assign rk_data   = rk_data_q;
  assign rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_hea_key_expand.sv
// Self-checking bench for hea_key_expand: vector table plus scoreboard driven
// by an independent log/antilog S-box model, and hand sequences for timing.
module tb_hea_key_expand;
  import hea_func_pack::*;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  hea_key_expand #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   idx;
  } beat_t;

  typedef struct {
    logic [127:0] key;
    bit           bp;
    int           ia;
    logic [127:0] ea;
    int           ib;
    logic [127:0] eb;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  beat_t        sb_q[$];
  logic [127:0] got [0:10];
  logic [7:0]   sbox_t [0:255];
  int           checks = 0;
  int           errors = 0;

  bit           stall_r = 1'b0;
  logic [127:0] stall_data;
  logic [3:0]   stall_idx;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box via generator-3 log/antilog tables and the bitwise affine definition.
  task automatic build_sbox();
    logic [7:0] exp_t [0:254];
    int         log_t [0:255];
    logic [7:0] e;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e ^ xt(e);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      for (int b = 0; b < 8; b++) begin
        s[b] = inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^ inv[(b + 6) % 8] ^
               inv[(b + 7) % 8] ^ c[b];
      end
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] m_next(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^
         {AES_RCON[r], 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic push_sched(input logic [127:0] key);
    logic [127:0] k;
    k = key;
    for (int r = 0; r <= 10; r++) begin
      sb_q.push_back({k, 4'(r)});
      if (r < 10) k = m_next(k, r + 1);
    end
  endtask

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stall_r = 1'b0;
    end else begin
      if (stall_r) begin
        chk("stall_data", rk_data, stall_data);
        chk("stall_idx", 128'(rk_idx), 128'(stall_idx));
      end
      if (rk_valid && rk_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d expected no beat", rk_idx);
        end else begin
          e = sb_q.pop_front();
          chk("rk_data", rk_data, e.data);
          chk("rk_idx", 128'(rk_idx), 128'(e.idx));
          chk("rk_last", 128'(rk_last), 128'(e.idx == 4'd10));
          got[rk_idx] = rk_data;
        end
      end
      stall_r    = rk_valid && !rk_ready;
      stall_data = rk_data;
      stall_idx  = rk_idx;
    end
  end

  task automatic drive_key(input logic [127:0] k);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!key_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL key_ready_timeout: got 0 expected 1");
    end
    key_in    = k;
    key_valid = 1'b1;
    push_sched(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic run_until_drained(input bit bp);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
    chk("idle_after_sched", 128'(key_ready), 128'(1'b1));
  endtask

  vec_t vecs[4];
  bit   seen5;

  initial begin
    vecs[0] = '{FIPS_KEY, 1'b0, 1, 128'ha0fafe1788542cb123a339392a6c7605, 10, FIPS_RK10};
    vecs[1] = '{128'h0, 1'b0, 1, 128'h62636363626363636263636362636363,
                2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[3] = '{FIPS_KEY, 1'b1, 5, 128'hd4d1c6f87c839d87caf2b8bc11f915bc, 10, FIPS_RK10};

    build_sbox();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = 128'h0;
    rk_ready  = 1'b0;
    #1;
    chk("reset_rk_valid", 128'(rk_valid), 128'(1'b0));
    chk("reset_rk_data", rk_data, 128'h0);
    chk("reset_rk_idx", 128'(rk_idx), 128'h0);
    chk("reset_rk_last", 128'(rk_last), 128'(1'b0));
    chk("reset_busy", 128'(busy), 128'(1'b0));
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_key_ready", 128'(key_ready), 128'(1'b1));

    // Table-driven vectors, with and without random backpressure.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i <= 10; i++) got[i] = 'x;
      rk_ready = vecs[v].bp ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_key(vecs[v].key);
      run_until_drained(vecs[v].bp);
      chk($sformatf("vec%0d_rk%0d", v, vecs[v].ia), got[vecs[v].ia], vecs[v].ea);
      chk($sformatf("vec%0d_rk%0d", v, vecs[v].ib), got[vecs[v].ib], vecs[v].eb);
    end

    // Consecutive beats at full rate; a second key pulsed mid-schedule is ignored.
    rk_ready = 1'b1;
    drive_key(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("burst_valid%0d", i), 128'(rk_valid), 128'(1'b1));
      chk($sformatf("burst_idx%0d", i), 128'(rk_idx), 128'(i));
      if (i == 3) begin
        key_in    = 128'hffeeddccbbaa99887766554433221100;
        key_valid = 1'b1;
      end
      if (i == 4) key_valid = 1'b0;
    end
    @(negedge clk);
    chk("burst_end_valid", 128'(rk_valid), 128'(1'b0));
    chk("burst_end_key_ready", 128'(key_ready), 128'(1'b1));
    @(negedge clk);
    chk("busy_key_not_taken", 128'(rk_valid), 128'(1'b0));
    chk("burst_sb_empty", 128'(sb_q.size()), 128'h0);

    // Back-to-back: second key held valid from the start of the first schedule.
    drive_key(128'h000102030405060708090a0b0c0d0e0f);
    key_in    = FIPS_KEY;
    key_valid = 1'b1;
    push_sched(FIPS_KEY);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_idx%0d", i), 128'(rk_idx), 128'(i));
    end
    @(negedge clk);
    chk("b2b_gap_key_ready", 128'(key_ready), 128'(1'b1));
    chk("b2b_gap_valid", 128'(rk_valid), 128'(1'b0));
    @(negedge clk);
    chk("b2b_second_valid", 128'(rk_valid), 128'(1'b1));
    chk("b2b_second_idx", 128'(rk_idx), 128'h0);
    key_valid = 1'b0;
    run_until_drained(1'b0);

    // Reset at rk_idx 5, then a full schedule for a fresh key.
    rk_ready = 1'b1;
    drive_key({$urandom, $urandom, $urandom, $urandom});
    seen5 = 1'b0;
    for (int n = 0; n < 20 && !seen5; n++) begin
      @(negedge clk);
      if (rk_idx == 4'd5) seen5 = 1'b1;
    end
    chk("reached_idx5", 128'(seen5), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rk_valid", 128'(rk_valid), 128'(1'b0));
    chk("midrst_rk_data", rk_data, 128'h0);
    chk("midrst_rk_idx", 128'(rk_idx), 128'h0);
    chk("midrst_rk_last", 128'(rk_last), 128'(1'b0));
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    sb_q.delete();
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_key_ready", 128'(key_ready), 128'(1'b1));
    for (int i = 0; i <= 10; i++) got[i] = 'x;
    drive_key(FIPS_KEY);
    run_until_drained(1'b0);
    chk("postrst_rk10", got[10], FIPS_RK10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
